ahb_sram_ws: RTL and testbench
==============================

AHB_SRAM_WS -- requirements
Module: ahb_sram_ws

Interface
REQ-001 Parameter MEMWIDTH, default 14, SHALL set the memory size in bytes to 2^MEMWIDTH, organised as 2^(MEMWIDTH-2) 32-bit words.
REQ-002 Parameter WAIT_STATES, default 1, legal range 0..7, SHALL set the number of HREADYOUT-low cycles inserted in every OKAY data phase.
REQ-003 Parameter INIT_FILE, default "" (empty), SHALL name a hex image loaded into memory at elaboration; an empty name SHALL mean no load.
REQ-004 Port list, in order: HCLK in 1 clock; HRESET in 1 asynchronous active-high reset; HSEL in 1 slave select; HREADY in 1 bus ready; HADDR in 32 address; HTRANS in 2 transfer type; HWRITE in 1 write flag; HSIZE in 3 transfer size; HWDATA in 32 write data; HREADYOUT out 1 slave ready; HRESP out 1 error response (1 = ERROR); HRDATA out 32 read data.
REQ-005 The block SHALL have one clock, HCLK, and one reset, HRESET, which is asynchronous and active-high.

Function
REQ-006 The block SHALL accept a transfer when HSEL=1, HREADY=1 and HTRANS[1]=1 (NONSEQ/SEQ) at a rising HCLK edge, and SHALL register HADDR, HWRITE and HSIZE at that edge.
REQ-007 The block SHALL give IDLE/BUSY transfers and unselected cycles a zero-wait OKAY response, with no memory access.
REQ-008 The FSM SHALL have states IDLE, WAIT, ERR1 and ERR2.
REQ-009 Transitions: on an accepted legal transfer, the FSM SHALL go IDLE->WAIT when WAIT_STATES>0 and stay in IDLE when WAIT_STATES=0; on an accepted illegal transfer it SHALL go to ERR1; then ERR1->ERR2 unconditionally; ERR2->IDLE, or ERR2->WAIT/ERR1 if a new transfer is accepted in the ERR2 cycle.
REQ-010 In WAIT, a down-counter loaded with WAIT_STATES SHALL hold HREADYOUT=0 for exactly WAIT_STATES cycles, then drive HREADYOUT=1 for one final data-phase cycle.
REQ-011 A transfer SHALL be illegal when any of these hold: HSIZE>2; halfword with HADDR[0]=1; word with HADDR[1:0]!=0.
REQ-012 An ERROR response SHALL be two cycles: ERR1 with HREADYOUT=0 and HRESP=1, then ERR2 with HREADYOUT=1 and HRESP=1.
REQ-013 An illegal transfer SHALL NOT modify memory.
REQ-014 Byte lanes SHALL be selected from the registered HSIZE and HADDR[1:0]:
- byte: lane HADDR[1:0];
- halfword: lanes 1:0 when HADDR[1]=0, lanes 3:2 when HADDR[1]=1;
- word: all four lanes.
REQ-015 A write SHALL sample HWDATA, update only the selected lanes of word HADDR[MEMWIDTH-1:2], and complete on the final data-phase cycle (HREADYOUT=1).
REQ-016 A read SHALL present the full 32-bit word at HADDR[MEMWIDTH-1:2] on HRDATA during the final data-phase cycle.
REQ-017 Outside a read's final data-phase cycle, HRDATA SHALL hold its last value.
REQ-018 Address bits HADDR[31:MEMWIDTH] SHALL be ignored, so accesses wrap modulo 2^MEMWIDTH.
REQ-019 Pipelining: a new address phase SHALL be accepted in the final data-phase cycle of the previous transfer; with WAIT_STATES=0, back-to-back transfers SHALL complete one per cycle.
REQ-020 A read whose address phase coincides with the completing data phase of a write to the same word SHALL return the newly written bytes (write-to-read forwarding) with no extra wait state.
REQ-021 While HREADYOUT=0, the block SHALL ignore HADDR, HTRANS, HWRITE and HSIZE.
REQ-022 HRESP SHALL be 0 in every OKAY cycle.

Reset
REQ-023 While HRESET=1: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, all registered address-phase state cleared.
REQ-024 A reset asserted mid-transfer SHALL abort the transfer without writing memory.
REQ-025 Memory contents SHALL NOT be altered by reset.
REQ-026 The first transfer SHALL be accepted on the first rising HCLK edge after HRESET deasserts.

Verification
REQ-027 Reset then reset release; with WAIT_STATES=2, word write 0xDEADBEEF to 0x10, then word read 0x10 -> each data phase holds HREADYOUT=0 for 2 cycles; read returns 0xDEADBEEF; HRESP=0 throughout.
REQ-028 WAIT_STATES=0: word write 0x11223344 to 0x20, then byte write 0xAA to 0x21, then word read 0x20 -> read returns 0x1122AA44; each transfer completes in one cycle; the byte write-to-read hazard is forwarded.
REQ-029 Halfword write 0xBEEF to 0x33, and separately word read 0x22 -> each gets ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); a word read of 0x30 is unchanged.
REQ-030 MEMWIDTH=14: word write 0xCAFEF00D to 0x4004, then read 0x0004 -> read returns 0xCAFEF00D (address wrap).
REQ-031 WAIT_STATES=3: HRESET asserted in the 2nd wait cycle of a write of 0x55555555 to 0x08 holding 0x0 -> HREADYOUT=1 and HRDATA=0 immediately; a later read of 0x08 returns 0x0.
REQ-032 HTRANS=IDLE with HSEL=1 interleaved between writes, and HSEL=0 with HTRANS=NONSEQ -> zero-wait OKAY and no memory change.

Source files
------------

// File: rtl/ahb_sram_ws.sv
// ahb_sram_ws: AHB-Lite SRAM slave with wait states, two-cycle error responses and write-to-read forwarding
module ahb_sram_ws #(
  parameter int MEMWIDTH = 14,
  parameter int WAIT_STATES = 1,
  parameter INIT_FILE = ""
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);
  localparam int AW = MEMWIDTH - 2;
  localparam logic [2:0] WS = 3'(WAIT_STATES);
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
  state_t state, state_nx;
  logic [2:0] cnt;
  logic [MEMWIDTH-1:0] addr_r;
  logic [1:0] size_r;
  logic write_r, act_r;
  logic acc, legal, fin, load_rd;
  logic [3:0] lanes;
  logic [AW-1:0] rd_idx;
  logic [31:0] rd_word;
  logic [31:0] mem [2**AW];
  logic unused;
  assign unused = ^{HADDR[31:MEMWIDTH], HTRANS[0]};
  assign HREADYOUT = state == ERR1 ? 1'b0 : state == WAIT ? cnt == 3'd0 : 1'b1;
  assign HRESP = state == ERR1 || state == ERR2;
  assign acc = HSEL & HREADY & HTRANS[1] & HREADYOUT;
  assign legal = !(HSIZE > 3'd2 || (HSIZE == 3'd1 && HADDR[0]) || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00));
  assign fin = act_r & HREADYOUT;
  assign lanes = size_r == 2'd0 ? 4'b0001 << addr_r[1:0] : size_r == 2'd1 ? (addr_r[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign load_rd = WS == 3'd0 ? acc && legal && !HWRITE : state == WAIT && cnt == 3'd1 && !write_r;
  assign rd_idx = WS == 3'd0 ? HADDR[MEMWIDTH-1:2] : addr_r[MEMWIDTH-1:2];
  always_comb begin
    rd_word = mem[rd_idx];
    for (int i = 0; i < 4; i++)
      if (fin && write_r && lanes[i] && addr_r[MEMWIDTH-1:2] == rd_idx) rd_word[8*i +: 8] = HWDATA[8*i +: 8];
  end
  always_comb begin
    state_nx = state;
    if (state == ERR1) state_nx = ERR2;
    else if (HREADYOUT) state_nx = !acc ? IDLE : !legal ? ERR1 : WS != 3'd0 ? WAIT : IDLE;
  end
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      state <= IDLE;
      cnt <= 3'd0;
      addr_r <= '0;
      size_r <= 2'd0;
      write_r <= 1'b0;
      act_r <= 1'b0;
      HRDATA <= 32'd0;
    end else begin
      state <= state_nx;
      cnt <= acc && legal ? WS : cnt != 3'd0 ? cnt - 3'd1 : cnt;
      if (acc) begin
        addr_r <= HADDR[MEMWIDTH-1:0];
        size_r <= HSIZE[1:0];
        write_r <= HWRITE;
      end
      act_r <= acc ? legal : act_r & ~fin;
      if (load_rd) HRDATA <= rd_word;
    end
  always_ff @(posedge HCLK)
    if (fin && write_r)
      for (int i = 0; i < 4; i++)
        if (lanes[i]) mem[addr_r[MEMWIDTH-1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
endmodule

// File: tb/tb_ahb_sram_ws.sv
// tb_ahb_sram_ws: directed and randomized checks of ahb_sram_ws at 0, 2 and 3 wait states
// against a byte-array memory model and a per-transfer response timeline.
module tb_ahb_sram_ws;
  localparam int N = 3;
  localparam int MW = 14;
  localparam int MSZ = 1 << MW;
  typedef struct {
    logic sel;
    logic [1:0] tr;
    logic w;
    logic [31:0] a;
    logic [2:0] s;
    logic [31:0] d;
  } xfer_t;
  logic clk = 0, rst = 0;
  logic sel[N], wr[N], ro[N], resp[N];
  logic [1:0] tr[N];
  logic [2:0] sz[N];
  logic [31:0] ad[N], wd[N], rd[N];
  logic [7:0] mm [N][MSZ];
  logic kn [N][MSZ];
  logic [31:0] last_v[N], last_m[N];
  xfer_t seq[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    ahb_sram_ws #(.MEMWIDTH(MW), .WAIT_STATES(g == 0 ? 0 : g + 1)) dut (
      .HCLK(clk), .HRESET(rst), .HSEL(sel[g]), .HREADY(ro[g]), .HADDR(ad[g]),
      .HTRANS(tr[g]), .HWRITE(wr[g]), .HSIZE(sz[g]), .HWDATA(wd[g]),
      .HREADYOUT(ro[g]), .HRESP(resp[g]), .HRDATA(rd[g]));
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic ok(xfer_t x);
    return x.s <= 3'd2 && !(x.s == 3'd1 && x.a[0]) && !(x.s == 3'd2 && x.a[1:0] != 2'b00);
  endfunction
  task automatic mwrite(input int d, input xfer_t x);
    int nb = 1 << x.s;
    for (int i = 0; i < nb; i++) begin
      logic [MW-1:0] b;
      b = x.a[MW-1:0] & ~MW'(nb - 1) | MW'(i);
      mm[d][b] = x.d[8*b[1:0] +: 8];
      kn[d][b] = 1'b1;
    end
  endtask
  task automatic mread(input int d, input logic [31:0] a, output logic [31:0] v, output logic [31:0] m);
    logic [MW-1:0] w;
    w = a[MW-1:0] & ~MW'(3);
    for (int i = 0; i < 4; i++) begin
      v[8*i +: 8] = mm[d][w | MW'(i)];
      m[8*i +: 8] = {8{kn[d][w | MW'(i)]}};
    end
  endtask
  task automatic drive(input int d, input xfer_t x);
    sel[d] = x.sel;
    tr[d] = x.tr;
    wr[d] = x.w;
    ad[d] = x.a;
    sz[d] = x.s;
  endtask
  task automatic put(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] dd);
    seq.push_back('{1'b1, 2'd2, w, a, s, dd});
  endtask
  task automatic put_nop(input logic sl, input logic [1:0] t);
    seq.push_back('{sl, t, 1'b1, 32'h40, 3'd2, 32'hFFFFFFFF});
  endtask
  // Plays seq on DUT d with AHB pipelining; each accepted legal transfer lasts ws+1 cycles
  // (ws low, one high), each illegal one two cycles, and memory changes when a write completes.
  task automatic run(input int d);
    xfer_t ap, dp, idle;
    logic dv, legal, erdy, eresp;
    logic [31:0] v, m;
    int cyc = 0, n = 0, budget = 0;
    int ws = d == 0 ? 0 : d + 1;
    idle = '{1'b1, 2'd0, 1'b0, 32'd0, 3'd0, 32'd0};
    dv = 1'b0;
    dp = idle;
    ap = idle;
    if (n < seq.size()) begin ap = seq[n]; n++; end
    drive(d, ap);
    wd[d] = 32'd0;
    while (n < seq.size() || (ap.sel && ap.tr[1]) || dv) begin
      budget++;
      if (budget > 4000) begin
        chk($sformatf("budget%0d", d), 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
      legal = dv && ok(dp);
      erdy = !dv || (legal ? cyc == ws : cyc == 1);
      eresp = dv && !legal;
      chk($sformatf("rdy%0d", d), 32'(ro[d]), 32'(erdy));
      chk($sformatf("resp%0d", d), 32'(resp[d]), 32'(eresp));
      if (legal && erdy && !dp.w) begin
        mread(d, dp.a, v, m);
        last_v[d] = v;
        last_m[d] = m;
      end
      chk($sformatf("rdata%0d", d), rd[d] & last_m[d], last_v[d] & last_m[d]);
      @(posedge clk);
      #1;
      if (erdy) begin
        if (legal && dp.w) mwrite(d, dp);
        dv = ap.sel && ap.tr[1];
        dp = ap;
        cyc = 0;
        ap = idle;
        if (n < seq.size()) begin ap = seq[n]; n++; end
        drive(d, ap);
        wd[d] = dp.d;
      end else cyc++;
    end
    seq.delete();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    xfer_t x;
    int r;
    for (int d = 0; d < N; d++) begin
      for (int i = 0; i < MSZ; i++) kn[d][i] = 1'b0;
      last_v[d] = 32'd0;
      last_m[d] = '1;
      drive(d, '{1'b0, 2'd0, 1'b0, 32'd0, 3'd0, 32'd0});
      wd[d] = 32'd0;
    end
    #1 rst = 1;
    #1;
    for (int d = 0; d < N; d++) begin
      chk($sformatf("rst_rdy%0d", d), 32'(ro[d]), 32'd1);
      chk($sformatf("rst_resp%0d", d), 32'(resp[d]), 32'd0);
      chk($sformatf("rst_rdata%0d", d), rd[d], 32'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    put(1, 32'h10, 3'd2, 32'hDEADBEEF);
    put(0, 32'h10, 3'd2, 32'd0);
    run(1);
    chk("ws2_read", rd[1], 32'hDEADBEEF);
    put(1, 32'h20, 3'd2, 32'h11223344);
    put(1, 32'h21, 3'd0, 32'h0000AA00);
    put(0, 32'h20, 3'd2, 32'd0);
    run(0);
    chk("fwd_read", rd[0], 32'h1122AA44);
    put(1, 32'h30, 3'd2, 32'h01020304);
    put(1, 32'h33, 3'd1, 32'hBEEF0000);
    put(0, 32'h22, 3'd2, 32'd0);
    put(0, 32'h30, 3'd2, 32'd0);
    run(1);
    chk("err_nowrite", rd[1], 32'h01020304);
    put(1, 32'h4004, 3'd2, 32'hCAFEF00D);
    put(0, 32'h0004, 3'd2, 32'd0);
    run(0);
    chk("wrap_read", rd[0], 32'hCAFEF00D);
    put(1, 32'h40, 3'd2, 32'hA5A5A5A5);
    put_nop(1, 2'd0);
    put(1, 32'h44, 3'd2, 32'h5A5A5A5A);
    put_nop(0, 2'd2);
    put_nop(1, 2'd1);
    put(0, 32'h44, 3'd2, 32'd0);
    put(0, 32'h40, 3'd2, 32'd0);
    run(2);
    chk("nop_nowrite", rd[2], 32'hA5A5A5A5);
    put(1, 32'h08, 3'd2, 32'd0);
    run(2);
    drive(2, '{1'b1, 2'd2, 1'b1, 32'h08, 3'd2, 32'd0});
    @(posedge clk);
    #1;
    drive(2, '{1'b1, 2'd0, 1'b0, 32'd0, 3'd0, 32'd0});
    wd[2] = 32'h55555555;
    @(posedge clk);
    #1;
    chk("pre_rst_rdy", 32'(ro[2]), 32'd0);
    rst = 1;
    #1;
    chk("mid_rst_rdy", 32'(ro[2]), 32'd1);
    chk("mid_rst_resp", 32'(resp[2]), 32'd0);
    chk("mid_rst_rdata", rd[2], 32'd0);
    for (int d = 0; d < N; d++) begin
      last_v[d] = 32'd0;
      last_m[d] = '1;
    end
    @(posedge clk);
    #1 rst = 0;
    put(0, 32'h08, 3'd2, 32'd0);
    run(2);
    chk("abort_read", rd[2], 32'd0);
    for (int d = 0; d < N; d++) begin
      for (int k = 0; k < 120; k++) begin
        r = $urandom_range(0, 9);
        x.sel = r != 0;
        x.tr = r == 1 ? 2'd0 : r == 2 ? 2'd1 : 2'($urandom_range(2, 3));
        x.w = 1'($urandom_range(0, 1));
        x.s = $urandom_range(0, 9) == 0 ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        x.a = 32'($urandom_range(0, 3) << 14) | 32'($urandom_range(0, 31));
        x.d = $urandom;
        seq.push_back(x);
      end
      run(d);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
